// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - load/store initiator for a word-wide data RAM
module mem_access_master #(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_din,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nxt;

  // Request fields latched at accept; only the low half of wdata is needed
  // after accept because word stores hand their data to mem_din directly.
  logic        lat_write, lat_write_nxt;
  logic [1:0]  lat_size, lat_size_nxt;
  logic        lat_unsigned, lat_unsigned_nxt;
  logic [1:0]  lat_offset, lat_offset_nxt;
  logic [15:0] lat_wdata, lat_wdata_nxt;

  logic        req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic        mem_we_nxt, mem_re_nxt;
  logic [31:0] rsp_rdata_nxt, mem_address_nxt, mem_din_nxt;

  logic        req_misaligned, req_out_of_range;
  logic [4:0]  lane_lsb;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] byte_mask, byte_ins;
  logic [31:0] load_data, merge_data;

  // Alignment check of the incoming request; size 11 is always rejected
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      2'b11:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_out_of_range = req_addr[31:2] >= 30'(DEPTH);

  // Big-endian lanes: byte offset 0 is the most significant byte
  assign lane_lsb  = {~lat_offset, 3'b000};
  assign lane_byte = mem_dout[lane_lsb +: 8];
  assign lane_half = lat_offset[1] ? mem_dout[15:0] : mem_dout[31:16];
  assign byte_mask = 32'h0000_00ff << lane_lsb;
  assign byte_ins  = {24'h0, lat_wdata[7:0]} << lane_lsb;

  // Load extraction and extension from the word being read this cycle
  always_comb begin
    load_data = mem_dout;
    case (lat_size)
      2'b00:   load_data = lat_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = lat_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = mem_dout;
    endcase
  end

  // Read-modify-write merge of the store lane(s) into the word being read
  always_comb begin
    merge_data = mem_dout;
    case (lat_size)
      2'b00:   merge_data = (mem_dout & ~byte_mask) | byte_ins;
      2'b01:   merge_data = lat_offset[1] ? {mem_dout[31:16], lat_wdata} : {lat_wdata, mem_dout[15:0]};
      default: merge_data = mem_dout;
    endcase
  end

  // Next state and next value of every registered output
  always_comb begin
    state_nxt        = state;
    lat_write_nxt    = lat_write;
    lat_size_nxt     = lat_size;
    lat_unsigned_nxt = lat_unsigned;
    lat_offset_nxt   = lat_offset;
    lat_wdata_nxt    = lat_wdata;
    req_ready_nxt    = 1'b0;
    rsp_valid_nxt    = 1'b0;
    rsp_err_nxt      = 1'b0;
    rsp_rdata_nxt    = 32'h0;
    mem_address_nxt  = mem_address;
    mem_din_nxt      = mem_din;
    mem_we_nxt       = 1'b0;
    mem_re_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          lat_write_nxt    = req_write;
          lat_size_nxt     = req_size;
          lat_unsigned_nxt = req_unsigned;
          lat_offset_nxt   = req_addr[1:0];
          lat_wdata_nxt    = req_wdata[15:0];
          if (req_misaligned || req_out_of_range) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
          end else if (!req_write || req_size != 2'b10) begin
            state_nxt       = RD;
            mem_re_nxt      = 1'b1;
            mem_address_nxt = {2'b00, req_addr[31:2]};
          end else begin
            state_nxt       = WR;
            mem_we_nxt      = 1'b1;
            mem_address_nxt = {2'b00, req_addr[31:2]};
            mem_din_nxt     = req_wdata;
          end
        end else begin
          req_ready_nxt = 1'b1;
        end
      end
      RD: begin
        if (lat_write) begin
          state_nxt   = WR;
          mem_we_nxt  = 1'b1;
          mem_din_nxt = merge_data;
        end else begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = load_data;
        end
      end
      WR: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
      end
      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lat_write        <= 1'b0;
      lat_size         <= 2'b00;
      lat_unsigned     <= 1'b0;
      lat_offset       <= 2'b00;
      lat_wdata        <= 16'h0;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= 32'h0;
      mem_address      <= 32'h0;
      mem_din          <= 32'h0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      state            <= state_nxt;
      lat_write        <= lat_write_nxt;
      lat_size         <= lat_size_nxt;
      lat_unsigned     <= lat_unsigned_nxt;
      lat_offset       <= lat_offset_nxt;
      lat_wdata        <= lat_wdata_nxt;
      req_ready        <= req_ready_nxt;
      rsp_valid        <= rsp_valid_nxt;
      rsp_err          <= rsp_err_nxt;
      rsp_rdata        <= rsp_rdata_nxt;
      mem_address      <= mem_address_nxt;
      mem_din          <= mem_din_nxt;
      mem_write_enable <= mem_we_nxt;
      mem_read_enable  <= mem_re_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// tb/tb_mem_access_master.sv - randomized self-checking bench for mem_access_master
module tb_mem_access_master;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_din, mem_dout;
  logic        mem_write_enable, mem_read_enable;

  mem_access_master #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_din(mem_din),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Attached RAM: combinational read, write on the rising edge
  logic [31:0] bench_ram [0:DEPTH-1];
  logic [31:0] init_word [0:DEPTH-1];
  logic        ram_init;

  assign mem_dout = (mem_read_enable && mem_address < DEPTH) ? bench_ram[mem_address[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) bench_ram[i] <= init_word[i];
    end else if (mem_write_enable && mem_address < DEPTH) begin
      bench_ram[mem_address[6:0]] <= mem_din;
    end
  end

  // Reference model: byte-addressed big-endian memory
  logic [7:0] ref_bytes [0:DEPTH*4-1];

  typedef struct {
    logic        ready;
    logic        rv;
    logic        chk_rsp;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic        re;
    logic        chk_addr;
    logic        chk_din;
    logic [31:0] addr;
    logic [31:0] din;
  } exp_t;

  exp_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rsp;
  logic        last_err;
  logic [31:0] last_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4], ref_bytes[idx*4+1], ref_bytes[idx*4+2], ref_bytes[idx*4+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    int          ia;
    ia = int'(a);
    if (sz == 2'b00) begin
      b = ref_bytes[ia];
      return u ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'b01) begin
      h = {ref_bytes[ia], ref_bytes[ia+1]};
      return u ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return {ref_bytes[ia], ref_bytes[ia+1], ref_bytes[ia+2], ref_bytes[ia+3]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int ia;
    ia = int'(a);
    if (sz == 2'b00) begin
      ref_bytes[ia] = d[7:0];
    end else if (sz == 2'b01) begin
      ref_bytes[ia] = d[15:8];
      ref_bytes[ia+1] = d[7:0];
    end else begin
      ref_bytes[ia] = d[31:24];
      ref_bytes[ia+1] = d[23:16];
      ref_bytes[ia+2] = d[15:8];
      ref_bytes[ia+3] = d[7:0];
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.ready = 1'b0; e.rv = 1'b0; e.chk_rsp = 1'b0; e.err = 1'b0; e.rdata = 32'h0;
    e.we = 1'b0; e.re = 1'b0; e.chk_addr = 1'b0; e.chk_din = 1'b0;
    e.addr = 32'h0; e.din = 32'h0;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = blank();
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = blank();
    e.ready = 1'b1; e.chk_rsp = 1'b1; e.chk_addr = 1'b1; e.chk_din = 1'b1;
    return e;
  endfunction

  // Per-cycle comparison of every DUT output against the queued expectation
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_ready", {31'h0, req_ready}, {31'h0, e.ready});
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, e.rv});
      chk("mem_write_enable", {31'h0, mem_write_enable}, {31'h0, e.we});
      chk("mem_read_enable", {31'h0, mem_read_enable}, {31'h0, e.re});
      if (e.chk_rsp) begin
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
      if (e.chk_addr) chk("mem_address", mem_address, e.addr);
      if (e.chk_din) chk("mem_din", mem_din, e.din);
      if (rsp_valid) begin
        last_rsp = rsp_rdata;
        last_err = rsp_err;
      end
      if (mem_write_enable) last_din = mem_din;
    end
  end

  task automatic drive_junk();
    req_valid    = 1'($urandom_range(0, 1));
    req_write    = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = $urandom();
    req_wdata    = $urandom();
  endtask

  // Present one request in an IDLE cycle and queue its expected cycles
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int          lat;
    logic        err;
    logic [31:0] idx;
    exp_t        e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    idx = a >> 2;
    err = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)
          || (a >= 32'(DEPTH * 4));
    if (err) begin
      e = blank(); e.rv = 1'b1; e.chk_rsp = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      lat = 1;
    end else if (!w) begin
      e = blank(); e.re = 1'b1; e.chk_addr = 1'b1; e.addr = idx;
      exp_q.push_back(e);
      e = blank(); e.rv = 1'b1; e.chk_rsp = 1'b1; e.rdata = ref_load(a, sz, u);
      exp_q.push_back(e);
      lat = 2;
    end else begin
      ref_store(a, sz, d);
      if (sz != 2'b10) begin
        e = blank(); e.re = 1'b1; e.chk_addr = 1'b1; e.addr = idx;
        exp_q.push_back(e);
      end
      e = blank(); e.we = 1'b1; e.chk_addr = 1'b1; e.addr = idx;
      e.chk_din = 1'b1; e.din = ref_word(int'(idx));
      exp_q.push_back(e);
      e = blank(); e.rv = 1'b1; e.chk_rsp = 1'b1;
      exp_q.push_back(e);
      lat = (sz == 2'b10) ? 2 : 3;
    end
    exp_q.push_back(idle_exp());
    repeat (lat) begin
      @(negedge clk);
      drive_junk();
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    exp_q.push_back(idle_exp());
  endtask

  initial begin
    logic [31:0] w, a;
    logic [1:0]  sz;
    exp_t        e;

    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      init_word[i] = w;
      ref_bytes[i*4] = w[31:24]; ref_bytes[i*4+1] = w[23:16];
      ref_bytes[i*4+2] = w[15:8]; ref_bytes[i*4+3] = w[7:0];
    end
    ram_init = 1'b1;
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234_5678;
    exp_q.push_back(reset_exp());
    exp_q.push_back(reset_exp());
    repeat (2) @(negedge clk);
    rst = 1'b0; ram_init = 1'b0; req_valid = 1'b0;
    exp_q.push_back(idle_exp());

    // Word round trip
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("word_store_din", last_din, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("word_load", last_rsp, 32'hDEAD_BEEF);

    // Byte read-modify-write and byte loads
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    chk("byte_rmw_din", last_din, 32'h11AA_3344);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("byte_load_signed", last_rsp, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("byte_load_unsigned", last_rsp, 32'h0000_00AA);

    // Half loads
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFF);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("half_load_hi", last_rsp, 32'hFFFF_8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("half_load_lo", last_rsp, 32'h0000_7FFF);

    // Errors
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    chk("err_misaligned_word", {31'h0, last_err}, 32'h1);
    do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF_FFFF);
    chk("err_misaligned_half", {31'h0, last_err}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    chk("err_out_of_range", {31'h0, last_err}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("mem_unchanged_after_err", last_rsp, 32'h8001_7FFF);

    // Reset during the read phase of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h55;
    e = blank(); e.re = 1'b1; e.chk_addr = 1'b1; e.addr = 32'h4;
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    exp_q.push_back(reset_exp());
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(idle_exp());
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("rmw_abandoned", last_rsp, 32'h0000_0001);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      case ($urandom_range(0, 9))
        0, 1, 2: sz = 2'b00;
        3, 4, 5: sz = 2'b01;
        6, 7, 8: sz = 2'b10;
        default: sz = 2'b11;
      endcase
      case ($urandom_range(0, 19))
        0:       a = $urandom();
        1, 2:    a = $urandom_range(DEPTH * 4, DEPTH * 4 + 64);
        default: a = $urandom_range(0, DEPTH * 4 - 1);
      endcase
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'b01) a = a & ~32'h1;
        if (sz == 2'b10) a = a & ~32'h3;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
    end

    idle_cycle();
    idle_cycle();
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("ram_final", bench_ram[i], ref_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
